// File: rtl/sr_mem_arb.sv
// Two-port arbiter onto a sync-read memory: grant -> mem_en next cycle -> ack 3 cycles after grant; one access per 4 cycles.
// No backpressure: a requester holds req until ack. Define SR_MEM_ARB_RR_EN for round-robin ties (default: port 0 wins ties).
module sr_mem_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          grantId;
  logic          grantWe;
  logic [AW-1:0] grantAddr;
  logic [DW-1:0] grantWdata;
  logic [DW-1:0] capData;
  logic          winner;

`ifdef SR_MEM_ARB_RR_EN
  logic ptr;
  // Tie goes to the pointer's port; a lone requester always wins.
  always_comb winner = (req0 && req1) ? ptr : ~req0;
`else
  always_comb winner = ~req0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grantId    <= 1'b0;
      grantWe    <= 1'b0;
      grantAddr  <= '0;
      grantWdata <= '0;
      capData    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
`ifdef SR_MEM_ARB_RR_EN
      ptr        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state      <= ISSUE;
            grantId    <= winner;
            grantWe    <= winner ? we1 : we0;
            grantAddr  <= winner ? addr1 : addr0;
            grantWdata <= winner ? wdata1 : wdata0;
            mem_en     <= 1'b1;
            mem_we     <= winner ? we1 : we0;
`ifdef SR_MEM_ARB_RR_EN
            ptr        <= ~winner;
`endif
          end
        end
        ISSUE: begin
          state  <= WAIT;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
        WAIT: begin
          // Memory data for the ISSUE-cycle read is valid now; writes report zero.
          state   <= RESP;
          capData <= grantWe ? '0 : mem_rdata;
          ack0    <= ~grantId;
          ack1    <= grantId;
        end
        default: begin
          state <= IDLE;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr  = mem_en ? grantAddr : '0;
  assign mem_wdata = mem_en ? grantWdata : '0;
  assign rdata0    = ack0 ? capData : '0;
  assign rdata1    = ack1 ? capData : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sr_mem_arb.sv
// Bench for sr_mem_arb: phase-counting access model checked every cycle plus directed literal checks.
module tb_sr_mem_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  int nTests = 0;
  int nFail  = 0;

  sr_mem_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory attached to the DUT.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[3:0]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: an access occupies 4 phases after grant (0 idle, 1 issue, 2 wait, 3 respond).
  logic [DW-1:0] refMem [16];
  bit            mValid = 1'b0;
  int            ph = 0;
  bit            gid, gwe, mPtr;
  logic [AW-1:0] gaddr;
  logic [DW-1:0] gwdata, mRd;

  always @(negedge clk) begin
    if (mValid) begin
      chk("m_busy",      64'(busy),      64'(ph != 0));
      chk("m_mem_en",    64'(mem_en),    64'(ph == 1));
      chk("m_mem_we",    64'(mem_we),    64'(ph == 1 && gwe));
      chk("m_mem_addr",  64'(mem_addr),  (ph == 1) ? 64'(gaddr) : 64'd0);
      chk("m_mem_wdata", 64'(mem_wdata), (ph == 1) ? 64'(gwdata) : 64'd0);
      chk("m_ack0",      64'(ack0),      64'(ph == 3 && !gid));
      chk("m_ack1",      64'(ack1),      64'(ph == 3 && gid));
      chk("m_rdata0",    64'(rdata0),    (ph == 3 && !gid && !gwe) ? 64'(mRd) : 64'd0);
      chk("m_rdata1",    64'(rdata1),    (ph == 3 && gid && !gwe) ? 64'(mRd) : 64'd0);
    end
    if (!rst_n) begin
      ph = 0; mPtr = 1'b0; mValid = 1'b1;
    end else if (mValid) begin
      case (ph)
        0: if (req0 || req1) begin
`ifdef SR_MEM_ARB_RR_EN
          gid = (req0 && req1) ? mPtr : req1;
`else
          gid = !req0;
`endif
          mPtr   = !gid;
          gwe    = gid ? we1 : we0;
          gaddr  = gid ? addr1 : addr0;
          gwdata = gid ? wdata1 : wdata0;
          ph = 1;
        end
        1: begin
          mRd = refMem[gaddr[3:0]];
          if (gwe) refMem[gaddr[3:0]] = gwdata;
          ph = 2;
        end
        2: ph = 3;
        default: ph = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Single access from one port starting in an idle cycle; checks latency and response.
  task automatic run(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] expRd);
    int cnt = 0;
    bit got = 0;
    if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    while (cnt < 12 && !got) begin
      @(negedge clk); cnt++;
      if (cnt == 2) begin
        chk("run_mem_en", 64'(mem_en), 64'd1);
        chk("run_mem_addr", 64'(mem_addr), 64'(a));
      end
      got = p ? ack1 : ack0;
    end
    chk("run_latency", 64'(cnt), 64'd4);
    chk("run_rdata", 64'(p ? rdata1 : rdata0), 64'(expRd));
    chk("run_other_ack", 64'(p ? ack0 : ack1), 64'd0);
    tick();
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("run_ack_one_cycle", 64'(p ? ack1 : ack0), 64'd0);
    chk("run_busy_after", 64'(busy), 64'd0);
  endtask

  int gq[$];
  task automatic collect(input int n);
    int cyc = 0;
    gq.delete();
    while (gq.size() < n && cyc < 10 * n) begin
      @(negedge clk); cyc++;
      if (ack0) gq.push_back(0);
      if (ack1) gq.push_back(1);
    end
    chk("collect_count", 64'(gq.size()), 64'(n));
  endtask

  initial begin
    int expOrder[4];
`ifdef SR_MEM_ARB_RR_EN
    expOrder = '{0, 1, 0, 1};
`else
    expOrder = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 16; i++) begin mem[i] = '0; refMem[i] = '0; end
    mem[1] = 32'h1111_1111; refMem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222; refMem[2] = 32'h2222_2222;
    rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ack0", 64'(ack0), 64'd0);
    chk("reset_mem_en", 64'(mem_en), 64'd0);
    chk("reset_rdata1", 64'(rdata1), 64'd0);
    tick();

    // Write through port 0, then read it back through port 1.
    run(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 32'h0);
    tick();
    run(1'b1, 1'b0, 32'd5, 32'h0, 32'hDEAD_BEEF);
    tick();

    // Both ports requesting continuously.
    req0 = 1; we0 = 0; addr0 = 32'd1;
    req1 = 1; we1 = 0; addr1 = 32'd2;
    collect(4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie_order%0d", i), (i < gq.size()) ? 64'(gq[i]) : 64'hFF, 64'(expOrder[i]));
    tick();
    req0 = 0; req1 = 0;
    tick(); tick();

    // Reset during the WAIT cycle of a write aborts it.
    req0 = 1; we0 = 1; addr0 = 32'd7; wdata0 = 32'h1234_5678;
    tick();            // sampled: ISSUE
    tick();            // WAIT
    rst_n = 0;
    tick();
    rst_n = 1; req0 = 0; we0 = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_mem_en", 64'(mem_en), 64'd0);
    chk("abort_mem_we", 64'(mem_we), 64'd0);
    chk("abort_ack0", 64'(ack0), 64'd0);
    tick();
    req0 = 1; addr0 = 32'd1; req1 = 1; addr1 = 32'd2;
    collect(1);
    chk("post_reset_tie", (gq.size() > 0) ? 64'(gq[0]) : 64'hFF, 64'd0);
    chk("post_reset_rdata0", 64'(rdata0), 64'h1111_1111);
    tick();
    req0 = 0; req1 = 0;
    tick(); tick();

    // Port 0 drops req right after being sampled.
    req0 = 1; we0 = 0; addr0 = 32'd5;
    tick();            // sampled at this edge
    req0 = 0;
    @(negedge clk);
    chk("drop_mem_en", 64'(mem_en), 64'd1);
    chk("drop_mem_addr", 64'(mem_addr), 64'd5);
    @(negedge clk);
    @(negedge clk);
    chk("drop_ack0", 64'(ack0), 64'd1);
    chk("drop_rdata0", 64'(rdata0), 64'hDEAD_BEEF);
    @(negedge clk);
    chk("drop_busy", 64'(busy), 64'd0);
    chk("drop_ack0_low", 64'(ack0), 64'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sr_mem_arb.md
SR_MEM_ARB -- requirements
Module: sr_mem_arb

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning word-address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 The block SHALL have ports req0/req1, input, 1 each, access request from port 0 (CPU data) and port 1 (debug/loader).
REQ-006 The block SHALL have ports we0/we1, input, 1 each, meaning 1 = write, 0 = read.
REQ-007 The block SHALL have ports addr0/addr1, input, AW each, word address.
REQ-008 The block SHALL have ports wdata0/wdata1, input, DW each, write data.
REQ-009 The block SHALL have ports ack0/ack1, output, 1 each, one-cycle completion pulse.
REQ-010 The block SHALL have ports rdata0/rdata1, output, DW each, read data, valid only while the matching ack is high.
REQ-011 The block SHALL have ports mem_en and mem_we, output, 1 each, memory access strobe and write enable.
REQ-012 The block SHALL have ports mem_addr, output, AW, and mem_wdata, output, DW, to memory.
REQ-013 The block SHALL have port mem_rdata, input, DW, from a synchronous-read memory (data is valid the cycle after mem_en).
REQ-014 The block SHALL have port busy, output, 1, meaning FSM not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with transitions IDLE->ISSUE (any req), ISSUE->WAIT, WAIT->RESP, RESP->IDLE, all unconditional except the first.
REQ-016 In IDLE with any req high, the block SHALL register the winner's id, we, addr and wdata; requester fields are sampled only at this edge.
REQ-017 In ISSUE, the block SHALL assert mem_en=1 and mem_we=latched we, and drive the latched addr/wdata; outside ISSUE, mem_en=mem_we=0 and mem_addr/mem_wdata=0.
REQ-018 In WAIT, the block SHALL capture mem_rdata into an internal register for reads and load 0 for writes.
REQ-019 In RESP, the block SHALL assert ack of the granted port only and drive that port's rdata from the captured register; the other port's ack/rdata SHALL be 0.
REQ-020 Latency SHALL be: req sampled at edge N, mem_en in cycle N+1, ack in cycle N+3; one access completes every 4 cycles maximum.
REQ-021 Requesters hold req and fields until ack and drop req in the cycle after ack; a req still high in IDLE after ack SHALL be treated as a new request.
REQ-022 If req drops before ack, the access SHALL still complete and ack SHALL still pulse.
REQ-023 When both reqs are high in IDLE, the winner SHALL be chosen by the policy in REQ-027/REQ-028; a single req SHALL always win.
REQ-024 busy SHALL be 1 in ISSUE, WAIT and RESP.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL set the FSM to IDLE, set the priority pointer to port 0, and clear the latched fields and captured data to 0; all outputs SHALL read 0 the following cycle.
REQ-026 A reset in ISSUE, WAIT or RESP SHALL abort the access with no ack, and mem_we SHALL be 0 from the next cycle.

Configuration
REQ-027 With macro SR_MEM_ARB_RR_EN defined, arbitration SHALL be round-robin: the pointer names the preferred port, ties go to it, and after each grant the pointer SHALL move to the other port.
REQ-028 With SR_MEM_ARB_RR_EN undefined, the block SHALL use fixed priority with port 0 winning every tie, and SHALL implement no pointer register.

Verification
REQ-029 A bench SHALL cover: req0=1, we0=1, addr0=5, wdata0=0xDEADBEEF at edge N -> mem_en=mem_we=1, mem_addr=5 in N+1; ack0=1, rdata0=0 in N+3.
REQ-030 A bench SHALL cover: memory word 5=0xDEADBEEF, req1 read of addr1=5 -> ack1 pulses for exactly 1 cycle with rdata1=0xDEADBEEF, and ack0=0 throughout.
REQ-031 A bench SHALL cover: req0 and req1 held continuously for 4 accesses -> grant order 0,1,0,1 with SR_MEM_ARB_RR_EN, and 0,0,0,0 without it.
REQ-032 A bench SHALL cover: rst_n=0 in the WAIT cycle of a write -> no ack, busy=0 and mem_en=0 the next cycle, and a subsequent tie grants port 0.
REQ-033 A bench SHALL cover: req0 dropped in the cycle after being sampled -> ack0 still pulses in N+3, and busy returns to 0 in N+4.
